alu_dispatch_buffer: RTL

In-order dispatch buffer that sits between rename and the ALU reservation station. It accepts renamed instruction bundles from rename and holds them in a circular queue. It writes up to PIPE_WIDTH entries per cycle into the RS, limited by the RS free-entry indication (`rs_rdy`). It is the producer end of the RS write interface (`rs_entry` / `rs_we` / `rs_rdy`).

---
 rtl/alu_dispatch_buffer_pkg.sv | 27 ++
 rtl/alu_dispatch_buffer_if.sv | 12 +
 rtl/alu_dispatch_buffer_multi_port_fifo.sv | 58 +++++
 rtl/alu_dispatch_buffer.sv | 39 +++
 4 files changed

// File: rtl/alu_dispatch_buffer_pkg.sv
// alu_dispatch_buffer_pkg: shared instruction type, dispatch widths and lane-count helpers
package alu_dispatch_buffer_pkg;
  localparam int PIPE_WIDTH = 3;
  localparam int ALU_DISP_DEPTH = 8;
  localparam int LANE_CW = $clog2(PIPE_WIDTH + 1);
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    logic [5:0]  dst;
    logic [5:0]  src1;
    logic [5:0]  src2;
  } instruction_t;
  function automatic logic [LANE_CW-1:0] popcount(input logic [PIPE_WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < PIPE_WIDTH; i++) popcount = popcount + LANE_CW'(v[i]);
  endfunction
  // number of consecutive ones from bit 0; anything above the first zero is ignored
  function automatic logic [LANE_CW-1:0] therm_count(input logic [PIPE_WIDTH-1:0] v);
    logic run;
    run = 1'b1;
    therm_count = '0;
    for (int i = 0; i < PIPE_WIDTH; i++) begin
      run = run & v[i];
      therm_count = therm_count + LANE_CW'(run);
    end
  endfunction
endpackage

// File: rtl/alu_dispatch_buffer_if.sv
// alu_dispatch_buffer_if: rename-side and RS-side handshake bundle of the dispatch buffer
interface alu_dispatch_buffer_if;
  import alu_dispatch_buffer_pkg::*;
  logic [PIPE_WIDTH-1:0]         ren_valid;
  instruction_t [PIPE_WIDTH-1:0] ren_bundle;
  logic                          ren_rdy;
  logic [PIPE_WIDTH-1:0]         rs_rdy;
  instruction_t [PIPE_WIDTH-1:0] rs_entry;
  logic [PIPE_WIDTH-1:0]         rs_we;
  modport master (input ren_valid, ren_bundle, rs_rdy, output ren_rdy, rs_entry, rs_we);
  modport slave (output ren_valid, ren_bundle, rs_rdy, input ren_rdy, rs_entry, rs_we);
endinterface

// File: rtl/alu_dispatch_buffer_multi_port_fifo.sv
// multi_port_fifo: circular queue with compacting multi-lane writes and lane-ordered reads from head
module multi_port_fifo
  import alu_dispatch_buffer_pkg::*;
#(
  parameter int DEPTH = ALU_DISP_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [PIPE_WIDTH-1:0]         wr_mask,
  input  instruction_t [PIPE_WIDTH-1:0] wr_data,
  input  logic [LANE_CW-1:0]            rd_cnt,
  output instruction_t [PIPE_WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH):0]        count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [LANE_CW-1:0] wr_cnt;
  instruction_t mem_q [DEPTH];
  instruction_t mem_d [DEPTH];
  // place each valid write lane in the next free slot after tail, in ascending lane order
  always_comb begin
    logic [LANE_CW-1:0] off;
    mem_d = mem_q;
    off = '0;
    for (int i = 0; i < PIPE_WIDTH; i++)
      if (wr_mask[i]) begin
        mem_d[tail_q + AW'(off)] = wr_data[i];
        off = off + LANE_CW'(1);
      end
  end
  // pointer and occupancy update; a clear discards all traffic of the cycle
  always_comb begin
    wr_cnt = popcount(wr_mask);
    head_d = clr ? '0 : head_q + AW'(rd_cnt);
    tail_d = clr ? '0 : tail_q + AW'(wr_cnt);
    count_d = clr ? '0 : count_q + CW'(wr_cnt) - CW'(rd_cnt);
  end
  // control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  // storage carries no reset; only slots between head and tail are ever read out
  always_ff @(posedge clk) mem_q <= mem_d;
  // read lane j always shows the entry j places behind head
  always_comb
    for (int j = 0; j < PIPE_WIDTH; j++) rd_data[j] = mem_q[head_q + AW'(j)];
  assign count = count_q;
endmodule

// File: rtl/alu_dispatch_buffer.sv
// alu_dispatch_buffer: in-order rename-to-RS dispatch queue with RS back-pressure, flush and stall
module alu_dispatch_buffer
  import alu_dispatch_buffer_pkg::*;
#(
  parameter int BUF_DEPTH = ALU_DISP_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       cache_stall,
  alu_dispatch_buffer_if.master      io,
  output logic [$clog2(BUF_DEPTH):0] buf_count
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  logic [LANE_CW-1:0] k, n;
  logic [PIPE_WIDTH-1:0] push_mask;
  instruction_t [PIPE_WIDTH-1:0] rd_data;
  // accept only with a whole bundle of room by registered count; dispatch min(count, RS room)
  always_comb begin
    io.ren_rdy = !flush && !cache_stall && (CW'(BUF_DEPTH) - buf_count >= CW'(PIPE_WIDTH));
    k = therm_count(io.rs_rdy);
    n = (flush || cache_stall) ? '0 : (CW'(k) < buf_count ? k : LANE_CW'(buf_count));
    push_mask = io.ren_rdy ? io.ren_valid : '0;
    for (int j = 0; j < PIPE_WIDTH; j++) begin
      io.rs_we[j] = LANE_CW'(j) < n;
      io.rs_entry[j] = io.rs_we[j] ? rd_data[j] : '0;
    end
  end
  multi_port_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .wr_mask(push_mask),
    .wr_data(io.ren_bundle),
    .rd_cnt(n),
    .rd_data(rd_data),
    .count(buf_count)
  );
endmodule
